cb_serial_collector: RTL and testbench
======================================

# cb_serial_collector

Serial-to-parallel collector sitting directly downstream of the commutator-buffer shift segment in the 64-point FFT datapath. Accepts the segment's serial word stream, packs every 8 consecutive words into a parallel frame, and presents the frame on eight output words with a valid/ready handshake. It is double-buffered: a collect bank and an output bank. When both are occupied it asserts `stall`, which drives the upstream segment's `hold`.

## Interface
- `DATA_WIDTH`, 32, width of each data word.
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  asynchronous, active-high reset.
- `flush`  in  1  synchronous clear of the partially collected frame.
- `in_valid`  in  1  `in_data` carries a word this cycle.
- `in_data`  in  DATA_WIDTH  serial word from the shift segment `Q`.
- `stall`  out  1  collect bank full and blocked; upstream must hold.
- `out_valid`  out  1  output bank holds a complete frame.
- `out_ready`  in  1  consumer accepts the frame this cycle.
- `Q0`..`Q7`  out  DATA_WIDTH each  frame words; `Q0` is the first serial word received, `Q7` the eighth.

## Operation
- Word accept: `acc = in_valid & ~stall`. Words presented while `stall=1` are ignored; upstream re-presents them after `stall` falls.
- Collect bank: eight word registers C0..C7 and counter `cnt` (0..8, 4 bits). On `acc`, `C[cnt] <= in_data`.
- Output bank free this cycle: `free = ~out_valid | out_ready`.
- Collector states:
  - COLLECT (`cnt` 0..7):
    - `acc` with `cnt<7` -> `cnt+1`.
    - `acc` with `cnt==7` and `free` -> transfer C0..C6 plus the current `in_data` (as `Q7`) into the output bank, set `out_valid`, `cnt<=0`.
    - `acc` with `cnt==7` and `~free` -> `C7<=in_data`, `cnt<=8`, enter WAIT.
  - WAIT (`cnt==8`): `stall=1`. When `free`, transfer C0..C7 to the output bank, set `out_valid`, `cnt<=0`.
- Output bank:
  - `out_ready & out_valid` with no transfer -> `out_valid<=0`.
  - Simultaneous accept and transfer -> `out_valid` stays 1 and the new frame replaces the old one.
  - `Q*` change only on a transfer.
- `flush`: `cnt<=0`, so any partial frame or WAIT frame is discarded and that cycle's input word is dropped. The output bank and `out_valid` are unaffected. `flush` has priority over `acc`.
- `stall = (cnt==8)`, decoded directly from the register with no combinational path from `out_ready`.

## Timing
- Reset values: `cnt=0`, `out_valid=0`, `stall=0`, `Q0`..`Q7`=0, C0..C7=0.
- Latency: 8th word accepted at edge N -> `out_valid=1` and frame on `Q*` after edge N, provided `free` held in that cycle.
- Throughput: 8 words per 8 cycles sustained, with no bubble, while the consumer keeps `out_ready=1` or drains in time.
- Blocked case: `stall` rises the cycle after the 8th word. It falls the cycle after the edge at which `free` is seen, and a new word can be accepted in that cycle.
- Reset mid-frame clears everything immediately and asynchronously; no partial frame is emitted after reset release.

## Structure
- Shared package `cb_pkg`:
  - `CB_DEPTH = 8`
  - `CB_CNT_W = 4`
  - state encoding constants `CB_COLLECT` and `CB_WAIT`, mirroring the `cnt==8` decode
- Sub-module `cb_word_reg`: DATA_WIDTH register with load enable and asynchronous high reset. Instantiated 16 times (C0..C7, Q0..Q7).
- Top holds the counter, the transfer/free logic and the output-bank mux (shifted-in word versus C7).

## Test plan
- Reset, then `in_data` = 1..8 on 8 consecutive cycles with `out_ready=1` -> after the 8th edge, `out_valid=1` and `Q0..Q7` = 1..8; `stall` never asserted.
- Continuous stream 1..24 with `out_ready=1` -> three frames (1..8, 9..16, 17..24) at 8-cycle spacing; no word lost; `stall=0` throughout.
- `out_ready=0`, stream 1..17 -> frame 1..8 held on `Q*`. Words 9..16 fill the collect bank and `stall` rises. Word 17 is ignored while `stall=1`. Raising `out_ready` for one cycle -> `Q*` = 9..16 and `stall` falls. Word 17 is then accepted as the first word of the next frame.
- Words 1..5, then `flush`, then words 6..13 -> frame `Q0..Q7` = 6..13; the earlier output bank is untouched.
- Assert `rst` after 6 words -> all outputs 0 asynchronously. After release, words 20..27 -> frame 20..27.
- In WAIT, pulse `out_ready` on the same cycle as `in_valid` -> the transfer occurs and that cycle's `in_valid` word is ignored because `stall=1`; the next-cycle word lands in C0.

Source files
------------

// File: rtl/cb_pkg.sv
// cb_pkg: shared collector depth, counter width and state encodings (CB_WAIT when cnt==CB_DEPTH)
package cb_pkg;
  localparam int CB_DEPTH = 8;
  localparam int CB_CNT_W = 4;
  localparam logic [0:0] CB_COLLECT = 1'b0;
  localparam logic [0:0] CB_WAIT = 1'b1;
endpackage

// File: rtl/cb_serial_collector_if.sv
// cb_serial_collector_if: collector bus; master=collector (in: flush/in_valid/in_data/out_ready, out: stall/out_valid/Q0..Q7), slave=environment
interface cb_serial_collector_if #(parameter int DATA_WIDTH = 32);
  logic flush, in_valid, stall, out_valid, out_ready;
  logic [DATA_WIDTH-1:0] in_data, Q0, Q1, Q2, Q3, Q4, Q5, Q6, Q7;
  modport master (
    input flush, in_valid, in_data, out_ready,
    output stall, out_valid, Q0, Q1, Q2, Q3, Q4, Q5, Q6, Q7
  );
  modport slave (
    output flush, in_valid, in_data, out_ready,
    input stall, out_valid, Q0, Q1, Q2, Q3, Q4, Q5, Q6, Q7
  );
endinterface

// File: rtl/cb_word_reg.sv
// cb_word_reg: WIDTH-bit register with load enable en, data d, output q; async active-high rst clears to 0
module cb_word_reg #(parameter int WIDTH = 32) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);
  always_ff @(posedge clk or posedge rst)
    if (rst) q <= '0;
    else if (en) q <= d;
endmodule

// File: rtl/cb_serial_collector.sv
// cb_serial_collector: double-buffered serial-to-8-word packer; clk, async rst, bus (master modport) carries stream input, stall, frame output handshake
module cb_serial_collector
  import cb_pkg::*;
#(parameter int DATA_WIDTH = 32) (
  input logic clk,
  input logic rst,
  cb_serial_collector_if.master bus
);
  logic [CB_CNT_W-1:0] cnt;
  logic [DATA_WIDTH-1:0] c [CB_DEPTH];
  logic [DATA_WIDTH-1:0] q [CB_DEPTH];
  logic [DATA_WIDTH-1:0] q_d [CB_DEPTH];
  logic [0:0] state;
  logic acc, free, xfer;
  assign state = cnt == CB_CNT_W'(CB_DEPTH) ? CB_WAIT : CB_COLLECT;
  assign bus.stall = state == CB_WAIT;
  assign acc = bus.in_valid & ~bus.stall;
  assign free = ~bus.out_valid | bus.out_ready;
  assign xfer = ~bus.flush & free & ((state == CB_WAIT) | (acc & (cnt == CB_CNT_W'(CB_DEPTH - 1))));
  for (genvar i = 0; i < CB_DEPTH; i++) begin : g_bank
    cb_word_reg #(.WIDTH(DATA_WIDTH)) u_c (
      .clk(clk), .rst(rst),
      .en(acc & ~bus.flush & (cnt == CB_CNT_W'(i))),
      .d(bus.in_data), .q(c[i])
    );
    // the last word bypasses C7 when the frame completes straight into a free output bank
    if (i == CB_DEPTH - 1) begin : g_last
      assign q_d[i] = state == CB_WAIT ? c[i] : bus.in_data;
    end else begin : g_mid
      assign q_d[i] = c[i];
    end
    cb_word_reg #(.WIDTH(DATA_WIDTH)) u_q (
      .clk(clk), .rst(rst), .en(xfer), .d(q_d[i]), .q(q[i])
    );
  end
  assign bus.Q0 = q[0];
  assign bus.Q1 = q[1];
  assign bus.Q2 = q[2];
  assign bus.Q3 = q[3];
  assign bus.Q4 = q[4];
  assign bus.Q5 = q[5];
  assign bus.Q6 = q[6];
  assign bus.Q7 = q[7];
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      cnt <= '0;
      bus.out_valid <= 1'b0;
    end else begin
      cnt <= (bus.flush | xfer) ? '0 : acc ? cnt + 1'b1 : cnt;
      bus.out_valid <= xfer | (bus.out_valid & ~bus.out_ready);
    end
endmodule

// File: tb/tb_cb_serial_collector.sv
// tb_cb_serial_collector: directed scoreboard bench for cb_serial_collector
module tb_cb_serial_collector;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int passed = 0;
  int total = 0;
  int failed = 0;
  logic [255:0] sb [$];

  cb_serial_collector_if #(.DATA_WIDTH(32)) bus ();
  cb_serial_collector #(.DATA_WIDTH(32)) dut (.clk(clk), .rst(rst), .bus(bus.master));

  always #5 clk = ~clk;

  function automatic logic [255:0] mk(input int base);
    logic [255:0] f;
    f = '0;
    for (int i = 0; i < 8; i++) f[32*i +: 32] = 32'(base + i);
    return f;
  endfunction

  function automatic logic [255:0] frame();
    return {bus.Q7, bus.Q6, bus.Q5, bus.Q4, bus.Q3, bus.Q2, bus.Q1, bus.Q0};
  endfunction

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: got %0h, want %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_frame(input string tag);
    logic [255:0] e;
    if (sb.size() == 0) begin
      total++;
      failed++;
      $error("FAIL %s: scoreboard empty, got %0h", tag, frame());
    end else begin
      e = sb.pop_front();
      chk(tag, frame(), e);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int w);
    bus.in_valid = 1'b1;
    bus.in_data = 32'(w);
    tick();
  endtask

  initial begin
    bus.flush = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data = '0;
    bus.out_ready = 1'b0;
    tick();
    chk("reset_out_valid", 256'(bus.out_valid), 256'd0);
    chk("reset_stall", 256'(bus.stall), 256'd0);
    chk("reset_q", frame(), '0);
    rst = 1'b0;
    tick();
    // single frame, consumer always ready
    bus.out_ready = 1'b1;
    sb.push_back(mk(1));
    for (int w = 1; w <= 8; w++) begin
      send(w);
      chk("t1_stall", 256'(bus.stall), 256'd0);
      if (w == 7) chk("t1_not_yet_valid", 256'(bus.out_valid), 256'd0);
    end
    chk("t1_valid", 256'(bus.out_valid), 256'd1);
    chk_frame("t1_frame");
    bus.in_valid = 1'b0;
    tick();
    chk("t1_drained", 256'(bus.out_valid), 256'd0);
    // sustained stream of three frames
    sb.push_back(mk(1));
    sb.push_back(mk(9));
    sb.push_back(mk(17));
    for (int w = 1; w <= 24; w++) begin
      send(w);
      chk("t2_stall", 256'(bus.stall), 256'd0);
      if (w % 8 == 0) begin
        chk("t2_valid", 256'(bus.out_valid), 256'd1);
        chk_frame("t2_frame");
      end
      if (w % 8 == 1 && w > 1) chk("t2_consumed", 256'(bus.out_valid), 256'd0);
    end
    bus.in_valid = 1'b0;
    tick();
    chk("t2_drained", 256'(bus.out_valid), 256'd0);
    // blocked consumer fills both banks
    bus.out_ready = 1'b0;
    sb.push_back(mk(1));
    for (int w = 1; w <= 16; w++) begin
      send(w);
      if (w == 8) chk_frame("t3_first_frame");
      if (w < 16) chk("t3_no_stall", 256'(bus.stall), 256'd0);
    end
    chk("t3_stall_up", 256'(bus.stall), 256'd1);
    chk("t3_held_frame", frame(), mk(1));
    send(17);
    chk("t3_stall_hold", 256'(bus.stall), 256'd1);
    chk("t3_held_frame2", frame(), mk(1));
    bus.out_ready = 1'b1;
    sb.push_back(mk(9));
    send(17);
    chk_frame("t3_wait_frame");
    chk("t3_stall_down", 256'(bus.stall), 256'd0);
    chk("t3_valid_kept", 256'(bus.out_valid), 256'd1);
    sb.push_back(mk(17));
    for (int w = 17; w <= 24; w++) send(w);
    chk("t3_next_valid", 256'(bus.out_valid), 256'd1);
    chk_frame("t3_next_frame");
    bus.in_valid = 1'b0;
    tick();
    chk("t3_drained", 256'(bus.out_valid), 256'd0);
    // flush discards partial frame, output bank untouched
    bus.out_ready = 1'b0;
    sb.push_back(mk(1));
    for (int w = 1; w <= 8; w++) send(w);
    chk_frame("t4_bank");
    for (int w = 101; w <= 105; w++) send(w);
    bus.flush = 1'b1;
    send(999);
    bus.flush = 1'b0;
    chk("t4_bank_valid", 256'(bus.out_valid), 256'd1);
    chk("t4_bank_kept", frame(), mk(1));
    chk("t4_no_stall", 256'(bus.stall), 256'd0);
    for (int w = 6; w <= 13; w++) send(w);
    chk("t4_wait", 256'(bus.stall), 256'd1);
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    sb.push_back(mk(6));
    tick();
    chk_frame("t4_frame");
    chk("t4_valid", 256'(bus.out_valid), 256'd1);
    tick();
    chk("t4_drained", 256'(bus.out_valid), 256'd0);
    // asynchronous reset mid-frame
    bus.out_ready = 1'b0;
    for (int w = 1; w <= 8; w++) send(w);
    chk("t5_pre_valid", 256'(bus.out_valid), 256'd1);
    for (int w = 1; w <= 6; w++) send(w);
    #2 rst = 1'b1;
    #1;
    chk("t5_async_valid", 256'(bus.out_valid), 256'd0);
    chk("t5_async_q", frame(), '0);
    chk("t5_async_stall", 256'(bus.stall), 256'd0);
    bus.in_valid = 1'b0;
    tick();
    rst = 1'b0;
    tick();
    bus.out_ready = 1'b1;
    sb.push_back(mk(20));
    for (int w = 20; w <= 27; w++) begin
      send(w);
      if (w == 26) chk("t5_no_early", 256'(bus.out_valid), 256'd0);
    end
    chk("t5_valid", 256'(bus.out_valid), 256'd1);
    chk_frame("t5_frame");
    bus.in_valid = 1'b0;
    tick();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
